// File: rtl/reg_writeback_queue_if.sv
// Handshake bundle between the writeback requesters (ALU, load unit) and the
// writeback queue, plus the register-file write port the queue drives.
interface reg_writeback_queue_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_dest;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_dest;
   logic [DATA_W-1:0] mem_data;
   logic              reg_write_en;
   logic [ADDR_W-1:0] reg_write_dest;
   logic [DATA_W-1:0] reg_write_data;

   modport master (
      output alu_valid, alu_dest, alu_data,
      output mem_valid, mem_dest, mem_data,
      input  alu_ready, mem_ready,
      input  reg_write_en, reg_write_dest, reg_write_data
   );

   modport slave (
      input  alu_valid, alu_dest, alu_data,
      input  mem_valid, mem_dest, mem_data,
      output alu_ready, mem_ready,
      output reg_write_en, reg_write_dest, reg_write_data
   );
endinterface

// File: rtl/reg_writeback_queue.sv
// In-order writeback FIFO feeding the register-file write port, with a pending-write
// hazard lookup. Define WB_BYPASS_EN to add the pend_data forwarding port.
module reg_writeback_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   reg_writeback_queue_if.slave      bus,
   input  logic                      drain_hold,
   input  logic [ADDR_W-1:0]         pend_addr,
   output logic                      pend_hit,
`ifdef WB_BYPASS_EN
   output logic [DATA_W-1:0]         pend_data,
`endif
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            fifo_q [DEPTH];
   entry_t            fifo_d [DEPTH];
   logic [PW-1:0]     wp_q, wp_d;
   logic [PW-1:0]     rp_q, rp_d;
   logic [CW-1:0]     count_q, count_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic   full;
   logic   push_mem, push_alu, push, pop;
   entry_t push_entry;

   // Readiness ignores a same-cycle pop, so a full queue never accepts.
   always_comb begin
      full          = (count_q == CW'(DEPTH));
      bus.mem_ready = rst_n && !full;
      bus.alu_ready = rst_n && !full && !bus.mem_valid;
      push_mem      = bus.mem_valid && bus.mem_ready;
      push_alu      = bus.alu_valid && bus.alu_ready;
      push          = push_mem || push_alu;
      pop           = (count_q != '0) && !drain_hold;
      push_entry    = push_mem ? entry_t'{bus.mem_dest, bus.mem_data}
                               : entry_t'{bus.alu_dest, bus.alu_data};
   end

   always_comb begin
      fifo_d    = fifo_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      count_d   = count_q;
      wr_en_d   = 1'b0;
      wr_dest_d = wr_dest_q;
      wr_data_d = wr_data_q;
      if (push) begin
         fifo_d[wp_q] = push_entry;
         wp_d         = wp_q + PW'(1);
      end
      if (pop) begin
         rp_d      = rp_q + PW'(1);
         wr_en_d   = 1'b1;
         wr_dest_d = fifo_q[rp_q].dest;
         wr_data_d = fifo_q[rp_q].data;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q      <= '0;
         rp_q      <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_dest_q <= '0;
         wr_data_q <= '0;
      end else begin
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_dest_q <= wr_dest_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   // Scan output stage first, then oldest to newest, so the youngest match wins.
   logic [PW-1:0] scan_idx;
`ifdef WB_BYPASS_EN
   logic [DATA_W-1:0] fwd_data;
`endif
   always_comb begin
      pend_hit = 1'b0;
      scan_idx = '0;
`ifdef WB_BYPASS_EN
      fwd_data = '0;
`endif
      if (wr_en_q && (wr_dest_q == pend_addr)) begin
         pend_hit = 1'b1;
`ifdef WB_BYPASS_EN
         fwd_data = wr_data_q;
`endif
      end
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rp_q + PW'(i);
         if ((CW'(i) < count_q) && (fifo_q[scan_idx].dest == pend_addr)) begin
            pend_hit = 1'b1;
`ifdef WB_BYPASS_EN
            fwd_data = fifo_q[scan_idx].data;
`endif
         end
      end
   end

`ifdef WB_BYPASS_EN
   assign pend_data = fwd_data;
`endif

   assign bus.reg_write_en   = wr_en_q;
   assign bus.reg_write_dest = wr_dest_q;
   assign bus.reg_write_data = wr_data_q;
   assign count              = count_q;

endmodule
